// File: rtl/if1_fetch_ctrl_pkg.sv
// Shared definitions for the IF1 fetch controller.
// Contents: the reset fetch address, the FSM state encoding, and an
// alignment helper used by the fetch controller.
package if1_fetch_ctrl_pkg;

    localparam logic [31:0] IF1_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ADEF = 2'd3
    } if1_state_e;

    // Instruction fetch addresses must be word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if1_fetch_ctrl_if.sv
// Instruction-cache request/response bundle between IF1 and the icache.
//   icache_req      : fetch request valid (IF1 -> cache)
//   icache_addr     : fetch address (IF1 -> cache)
//   icache_addr_ok  : request accepted this cycle (cache -> IF1)
//   icache_data_ok  : outstanding request returned this cycle (cache -> IF1)
// master = fetch controller side, slave = cache side.
interface if1_fetch_ctrl_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;

    modport master (output icache_req, icache_addr,
                    input  icache_addr_ok, icache_data_ok);
    modport slave  (input  icache_req, icache_addr,
                    output icache_addr_ok, icache_data_ok);
endinterface

// File: rtl/if1_fetch_ctrl_npc.sv
// Next fetch PC selection for IF1.
//   pc_i         : current fetch PC
//   redirect_i   : pipeline redirect (highest priority), ex_target_i its target
//   advance_i    : current fetch accepted by the icache this cycle
//   bp_taken_i   : predictor says taken, bp_target_i its target
//   npc_o        : PC to load next cycle (holds pc_i when nothing happens)
module if1_npc (
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [31:0] ex_target_i,
    input  logic        advance_i,
    input  logic        bp_taken_i,
    input  logic [31:0] bp_target_i,
    output logic [31:0] npc_o
);

    // Redirect beats prediction; sequential step wraps modulo 2^32.
    always_comb begin
        npc_o = pc_i;
        if (redirect_i) begin
            npc_o = ex_target_i;
        end else if (advance_i) begin
            if (bp_taken_i) begin
                npc_o = bp_target_i;
            end else begin
                npc_o = pc_i + 32'd4;
            end
        end else begin
            npc_o = pc_i;
        end
    end

endmodule

// File: rtl/if1_fetch_ctrl.sv
// IF1 fetch controller: issues one icache request at a time, tracks the
// outstanding response, handles redirects/predictions and alignment faults,
// and presents the fetch slot to IF2.
//   clk, rst_n          : clock, synchronous active-low reset
//   stall_in            : IF2/ID register not writing; blocks new requests
//   ex_redirect/target  : pipeline flush and new fetch target
//   bp_taken/bp_target  : prediction for the current fetch PC
//   icache (master)     : request/response bundle to the icache
//   if2_pc/adef/branch_bp, if1_if2_cache_valid, if1_if2_flushed : IF2 slot
module if1_fetch_ctrl
    import if1_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF1_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_in,
    input  logic                     ex_redirect,
    input  logic [31:0]              ex_target,
    input  logic                     bp_taken,
    input  logic [31:0]              bp_target,
    if1_fetch_ctrl_if.master         icache,
    output logic [31:0]              if2_pc,
    output logic                     if2_adef,
    output logic                     if2_branch_bp,
    output logic                     if1_if2_cache_valid,
    output logic                     if1_if2_flushed
);

    if1_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] if2_pc_q, if2_pc_d;
    logic        if2_adef_q, if2_adef_d;
    logic        if2_bp_q, if2_bp_d;

    logic        misalign_s;
    logic        req_s;
    logic        accept_s;
    logic        resp_s;
    logic        adef_enter_s;
    logic [31:0] npc_s;

    // Event decode shared by the FSM and datapath.
    always_comb begin
        misalign_s   = pc_misaligned(pc_q);
        req_s        = (state_q == ST_REQ) && !stall_in && !misalign_s;
        accept_s     = req_s && icache.icache_addr_ok;
        resp_s       = (state_q == ST_WAIT) && icache.icache_data_ok;
        adef_enter_s = (state_q == ST_REQ) && !stall_in && misalign_s && !ex_redirect;
    end

    if1_npc u_npc (
        .pc_i        (pc_q),
        .redirect_i  (ex_redirect),
        .ex_target_i (ex_target),
        .advance_i   (accept_s),
        .bp_taken_i  (bp_taken),
        .bp_target_i (bp_target),
        .npc_o       (npc_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a redirect in REQ/WAIT keeps the state and
    // relies on the discard flag to kill the in-flight fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (accept_s) begin
                    state_d = ST_WAIT;
                end else if (adef_enter_s) begin
                    state_d = ST_ADEF;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (resp_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ADEF: begin
                if (ex_redirect) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_ADEF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: request and IF2 slot qualifiers.
    always_comb begin
        icache.icache_req   = req_s;
        icache.icache_addr  = req_s ? pc_q : 32'h0000_0000;
        if1_if2_cache_valid = resp_s && !discard_q && !ex_redirect;
        if1_if2_flushed     = !if1_if2_cache_valid && !if2_adef_q;
        if2_pc              = if2_pc_q;
        if2_adef            = if2_adef_q;
        if2_branch_bp       = if2_bp_q;
    end

    // Datapath next values: PC, discard flag and IF2 slot registers.
    always_comb begin
        pc_d       = npc_s;
        discard_d  = discard_q;
        if2_pc_d   = if2_pc_q;
        if2_adef_d = if2_adef_q;
        if2_bp_d   = if2_bp_q;

        // The response that retires the outstanding fetch always clears
        // discard; a request accepted during a redirect is born discarded.
        if (resp_s) begin
            discard_d = 1'b0;
        end else if (accept_s) begin
            discard_d = ex_redirect;
        end else if ((state_q == ST_WAIT) && ex_redirect) begin
            discard_d = 1'b1;
        end else begin
            discard_d = discard_q;
        end

        if (ex_redirect) begin
            if2_adef_d = 1'b0;
            if2_bp_d   = 1'b0;
        end else if (accept_s) begin
            if2_pc_d   = pc_q;
            if2_adef_d = 1'b0;
            if2_bp_d   = bp_taken;
        end else if (adef_enter_s) begin
            if2_pc_d   = pc_q;
            if2_adef_d = 1'b1;
            if2_bp_d   = 1'b0;
        end else begin
            if2_pc_d   = if2_pc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            if2_pc_q   <= 32'h0000_0000;
            if2_adef_q <= 1'b0;
            if2_bp_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            if2_pc_q   <= if2_pc_d;
            if2_adef_q <= if2_adef_d;
            if2_bp_q   <= if2_bp_d;
        end
    end

endmodule

// File: tb/tb_if1_fetch_ctrl.sv
// Self-checking bench for if1_fetch_ctrl: a behavioural icache with
// programmable accept/return latency, a reference model of the fetch
// sequence, and a scoreboard of accepted fetches checked on response.
module tb_if1_fetch_ctrl;
    import if1_fetch_ctrl_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic        bp;
        logic        killed;
    } ent_t;

    localparam logic [31:0] NO_BP = 32'hffff_ffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        bp_taken = 1'b0;
    logic [31:0] bp_target = 32'h0;
    logic [31:0] if2_pc;
    logic        if2_adef;
    logic        if2_branch_bp;
    logic        cache_valid;
    logic        flushed;

    if1_fetch_ctrl_if bus ();

    if1_fetch_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stall_in            (stall_in),
        .ex_redirect         (ex_redirect),
        .ex_target           (ex_target),
        .bp_taken            (bp_taken),
        .bp_target           (bp_target),
        .icache              (bus),
        .if2_pc              (if2_pc),
        .if2_adef            (if2_adef),
        .if2_branch_bp       (if2_branch_bp),
        .if1_if2_cache_valid (cache_valid),
        .if1_if2_flushed     (flushed)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    // reference model
    if1_state_e  mstate;
    logic [31:0] exp_pc, exp_if2pc;
    logic        exp_adef, exp_bp;
    ent_t        sb[$];
    logic [31:0] issued[$];
    int          cv_count;

    // icache model
    int          ack_dly = 1;
    int          data_lat = 1;
    int          req_wait = 0;
    int          dcnt = 0;
    bit          outstanding = 1'b0;
    bit          spur_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst_n = 1'b0; stall_in = 1'b0; ex_redirect = 1'b0; bp_taken = 1'b0;
            bus.icache_addr_ok = 1'b0;
            bus.icache_data_ok = (i == 0);
        end
        // IDLE cycle after release; stray handshakes must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        bus.icache_addr_ok = 1'b1;
        bus.icache_data_ok = 1'b1;
        #1;
        check_val("rst_req", 32'(bus.icache_req), 32'd0);
        check_val("rst_addr", bus.icache_addr, 32'h0);
        check_val("rst_if2_pc", if2_pc, 32'h0);
        check_val("rst_adef", 32'(if2_adef), 32'd0);
        check_val("rst_bp", 32'(if2_branch_bp), 32'd0);
        check_val("rst_cache_valid", 32'(cache_valid), 32'd0);
        check_val("rst_flushed", 32'(flushed), 32'd1);
        mstate = ST_REQ;
        exp_pc = IF1_RESET_PC; exp_if2pc = 32'h0; exp_adef = 1'b0; exp_bp = 1'b0;
        sb.delete(); issued.delete();
        outstanding = 1'b0; req_wait = 0; dcnt = 0; cv_count = 0;
    endtask

    task automatic cycle(input bit st, input bit rd, input logic [31:0] rt,
                         input logic [31:0] bp_pc, input logic [31:0] bp_tgt);
        bit   exp_req, aok, dok, real_dok, bt, killed;
        ent_t e;
        @(negedge clk);
        stall_in = st; ex_redirect = rd; ex_target = rt; bp_target = bp_tgt;
        if (outstanding) dcnt--;
        real_dok = outstanding && (dcnt <= 0);
        exp_req  = (mstate == ST_REQ) && !st && (exp_pc[1:0] == 2'b00);
        aok = exp_req && (req_wait >= ack_dly);
        if (spur_en && !exp_req && ($urandom_range(0, 1) == 1)) aok = 1'b1;
        dok = real_dok || (spur_en && !outstanding && ($urandom_range(0, 1) == 1));
        bt  = exp_req && (exp_pc == bp_pc);
        bp_taken = bt;
        bus.icache_addr_ok = aok;
        bus.icache_data_ok = dok;
        #1;
        check_val("icache_req", 32'(bus.icache_req), 32'(exp_req));
        if (exp_req) check_val("icache_addr", bus.icache_addr, exp_pc);
        check_val("if2_pc", if2_pc, exp_if2pc);
        check_val("if2_adef", 32'(if2_adef), 32'(exp_adef));
        check_val("if2_branch_bp", 32'(if2_branch_bp), 32'(exp_bp));
        if (bus.icache_req && aok) issued.push_back(bus.icache_addr);
        if (cache_valid) cv_count++;
        if (real_dok) begin
            check_val("sb_size", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                killed = e.killed || rd;
                check_val("resp_cache_valid", 32'(cache_valid), 32'(!killed));
                check_val("resp_flushed", 32'(flushed), 32'(killed));
                if (!killed) begin
                    check_val("resp_pc", if2_pc, e.pc);
                    check_val("resp_bp", 32'(if2_branch_bp), 32'(e.bp));
                end
            end
        end else begin
            check_val("idle_cache_valid", 32'(cache_valid), 32'd0);
            check_val("idle_flushed", 32'(flushed), 32'(!exp_adef));
        end

        // model update for the coming edge
        if (exp_req && aok) req_wait = 0;
        else if (exp_req) req_wait++;
        if (real_dok) outstanding = 1'b0;
        if (rd) begin
            case (mstate)
                ST_REQ: begin
                    if (exp_req && aok) begin
                        sb.push_back(ent_t'{pc: exp_pc, bp: bt, killed: 1'b1});
                        outstanding = 1'b1; dcnt = data_lat; mstate = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (real_dok) mstate = ST_REQ;
                    else if (sb.size() != 0) sb[0].killed = 1'b1;
                end
                default: mstate = ST_REQ;
            endcase
            exp_pc = rt; exp_adef = 1'b0; exp_bp = 1'b0;
        end else begin
            case (mstate)
                ST_IDLE: mstate = ST_REQ;
                ST_REQ: begin
                    if (exp_req && aok) begin
                        sb.push_back(ent_t'{pc: exp_pc, bp: bt, killed: 1'b0});
                        outstanding = 1'b1; dcnt = data_lat;
                        exp_if2pc = exp_pc; exp_bp = bt; exp_adef = 1'b0;
                        exp_pc = bt ? bp_tgt : exp_pc + 32'd4;
                        mstate = ST_WAIT;
                    end else if (!st && (exp_pc[1:0] != 2'b00)) begin
                        mstate = ST_ADEF; exp_adef = 1'b1; exp_if2pc = exp_pc; exp_bp = 1'b0;
                    end
                end
                ST_WAIT: if (real_dok) mstate = ST_REQ;
                default: ;
            endcase
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, NO_BP, 32'h0);
    endtask

    task automatic wait_state(input if1_state_e target);
        for (int i = 0; i < 30 && mstate != target; i++) run(1);
        check_val("reach_state", 32'(mstate), 32'(target));
    endtask

    task automatic check_issued(input string tag, input int idx, input logic [31:0] exp);
        check_val({tag, "_present"}, 32'(issued.size() > idx), 32'd1);
        if (issued.size() > idx) check_val(tag, issued[idx], exp);
    endtask

    initial begin
        int idx;
        bus.icache_addr_ok = 1'b0;
        bus.icache_data_ok = 1'b0;

        // in-order sequential fetch, 1-cycle accept and return
        do_reset(3);
        ack_dly = 1; data_lat = 1;
        run(9);
        check_issued("seq0", 0, 32'h1c00_0000);
        check_issued("seq1", 1, 32'h1c00_0004);
        check_issued("seq2", 2, 32'h1c00_0008);
        check_val("cv_pulses", 32'(cv_count), 32'd3);

        // predicted-taken at the second fetch
        do_reset(2);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 32'h1c00_0004, 32'h1c00_0100);
        check_issued("bp1", 1, 32'h1c00_0004);
        check_issued("bp2", 2, 32'h1c00_0100);

        // redirect during WAIT, response 3 cycles later is killed
        data_lat = 4;
        wait_state(ST_WAIT);
        cycle(1'b0, 1'b1, 32'h1c00_0200, NO_BP, 32'h0);
        idx = issued.size();
        run(6);
        check_issued("redir_wait", idx, 32'h1c00_0200);

        // misaligned redirect raises an address fault, then recover
        data_lat = 1;
        wait_state(ST_REQ);
        cycle(1'b0, 1'b1, 32'h1c00_0003, NO_BP, 32'h0);
        run(4);
        @(posedge clk); #1;
        check_val("adef_flag", 32'(if2_adef), 32'd1);
        check_val("adef_pc", if2_pc, 32'h1c00_0003);
        cycle(1'b0, 1'b1, 32'h1c00_0010, NO_BP, 32'h0);
        idx = issued.size();
        run(4);
        check_issued("adef_resume", idx, 32'h1c00_0010);

        // stall for 4 cycles after a response
        ack_dly = 0;
        wait_state(ST_WAIT);
        run(1);
        idx = issued.size();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, NO_BP, 32'h0);
        check_val("stall_no_req", 32'(issued.size()), 32'(idx));
        run(1);
        check_val("stall_resume", 32'(issued.size()), 32'(idx + 1));

        // PC wrap at the top of the address space
        wait_state(ST_REQ);
        cycle(1'b0, 1'b1, 32'hffff_fffc, NO_BP, 32'h0);
        idx = issued.size();
        run(8);
        check_issued("wrap_top", idx, 32'hffff_fffc);
        check_issued("wrap_zero", idx + 1, 32'h0000_0000);

        // reset in the middle of an outstanding fetch
        data_lat = 3;
        wait_state(ST_WAIT);
        do_reset(2);
        run(6);

        // randomized traffic with stray handshakes
        spur_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit          st, rd;
            logic [31:0] tgt, bpp;
            if (i % 50 == 0) begin
                ack_dly  = $urandom_range(0, 2);
                data_lat = $urandom_range(1, 3);
            end
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            tgt = $urandom() & 32'hffff_fffc;
            if ($urandom_range(0, 3) == 0) tgt = tgt | 32'h0000_0002;
            bpp = ($urandom_range(0, 2) == 0) ? exp_pc : NO_BP;
            cycle(st, rd, tgt, bpp, $urandom() & 32'hffff_fffc);
        end
        spur_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
